cp0_regfile: RTL and testbench

//  CP0 system-control register file. Responder end of the WB<->C0 register access

---
 rtl/cp0_regfile.sv | 303 ++++++++++++++++++++++++++++++
 tb/tb_cp0_regfile.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/cp0_regfile.sv
// -----------------------------------------------------------------------------
// cp0_regfile -- CP0 system-control register file.
//
// Serves MFC0 reads / MTC0 writes from the WB stage, takes exception and ERET
// commits from WB, runs the Count/Compare timer and raises the interrupt
// request seen by the pipeline.
//
// Register map (wb_addr = {rd[4:0], sel[2:0]}, only sel==0 decoded):
//   8 BadVAddr (RO)   9 Count   11 Compare   12 Status   13 Cause   14 EPC
//   With CP0_TLB_REGS_EN: 0 Index, 2 EntryLo0, 3 EntryLo1, 10 EntryHi
//
// Optional feature macro: CP0_TLB_REGS_EN (adds the TLB registers and ports).
//
// Ports:
//   clk, resetn              clock, asynchronous active-low reset
//   wb_we/wb_addr/wb_wdata   MTC0 write strobe, address, data
//   wb_rdata                 MFC0 read data (combinational)
//   ex_valid/ex_exccode/ex_bd/ex_pc/ex_badvaddr   exception commit
//   eret                     ERET commit
//   ext_int[5:0]             hardware interrupt lines
//   epc_out, exc_target      ERET target, exception vector
//   status_exl, int_req      Status.EXL, pending-and-enabled interrupt
//   (TLB build) tlbp_*, tlbr_*, index_out, entryhi_out, entrylo0/1_out
// -----------------------------------------------------------------------------
module cp0_regfile #(
  parameter logic [31:0] EXC_BASE = 32'hBFC0_0380,
  parameter int          ERET_CHK = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        wb_we,
  input  logic [7:0]  wb_addr,
  input  logic [31:0] wb_wdata,
  output logic [31:0] wb_rdata,
  input  logic        ex_valid,
  input  logic [4:0]  ex_exccode,
  input  logic        ex_bd,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_badvaddr,
  input  logic        eret,
  input  logic [5:0]  ext_int,
`ifdef CP0_TLB_REGS_EN
  input  logic        tlbp_valid,
  input  logic [31:0] tlbp_result,
  input  logic        tlbr_valid,
  input  logic [31:0] tlbr_hi,
  input  logic [31:0] tlbr_lo0,
  input  logic [31:0] tlbr_lo1,
  output logic [31:0] index_out,
  output logic [31:0] entryhi_out,
  output logic [31:0] entrylo0_out,
  output logic [31:0] entrylo1_out,
`endif
  output logic [31:0] epc_out,
  output logic [31:0] exc_target,
  output logic        status_exl,
  output logic        int_req
);

  localparam logic [4:0] EXCCODE_MOD  = 5'd1;
  localparam logic [4:0] EXCCODE_TLBL = 5'd2;
  localparam logic [4:0] EXCCODE_TLBS = 5'd3;
  localparam logic [4:0] EXCCODE_ADEL = 5'd4;
  localparam logic [4:0] EXCCODE_ADES = 5'd5;

  localparam logic [4:0] RD_INDEX    = 5'd0;
  localparam logic [4:0] RD_ENTRYLO0 = 5'd2;
  localparam logic [4:0] RD_ENTRYLO1 = 5'd3;
  localparam logic [4:0] RD_BADVADDR = 5'd8;
  localparam logic [4:0] RD_COUNT    = 5'd9;
  localparam logic [4:0] RD_ENTRYHI  = 5'd10;
  localparam logic [4:0] RD_COMPARE  = 5'd11;
  localparam logic [4:0] RD_STATUS   = 5'd12;
  localparam logic [4:0] RD_CAUSE    = 5'd13;
  localparam logic [4:0] RD_EPC      = 5'd14;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [7:0]  status_im;
  logic        status_exl_q;
  logic        status_ie;
  logic        cause_bd;
  logic        cause_ti;
  logic [1:0]  cause_ip_sw;
  logic [4:0]  cause_exccode;
  logic [31:0] count;
  logic        tick;
  logic [31:0] compare;
  logic [31:0] epc;
  logic [31:0] badvaddr;

  // ---------------------------------------------------------------------------
  // Write decode
  // ---------------------------------------------------------------------------
  logic [4:0] wr_rd;
  logic       wr_sel0;
  logic       we_count, we_compare, we_status, we_cause, we_epc;

  assign wr_rd      = wb_addr[7:3];
  assign wr_sel0    = wb_we && (wb_addr[2:0] == 3'd0);
  assign we_count   = wr_sel0 && (wr_rd == RD_COUNT);
  assign we_compare = wr_sel0 && (wr_rd == RD_COMPARE);
  assign we_status  = wr_sel0 && (wr_rd == RD_STATUS);
  assign we_cause   = wr_sel0 && (wr_rd == RD_CAUSE);
  assign we_epc     = wr_sel0 && (wr_rd == RD_EPC);

  logic        bva_update;
  logic        epc_update;
  logic [31:0] ex_epc;

`ifdef CP0_TLB_REGS_EN
  logic is_tlb_exc;
  assign is_tlb_exc = (ex_exccode == EXCCODE_MOD)  || (ex_exccode == EXCCODE_TLBL) ||
                      (ex_exccode == EXCCODE_TLBS);
  assign bva_update = ex_valid && (is_tlb_exc || ex_exccode == EXCCODE_ADEL ||
                                   ex_exccode == EXCCODE_ADES);
`else
  assign bva_update = ex_valid && (ex_exccode == EXCCODE_ADEL || ex_exccode == EXCCODE_ADES);
`endif

  // EPC and BD are only captured for the first exception; nested ones
  // (taken while EXL is set) must keep the original return point.
  assign epc_update = ex_valid && !status_exl_q;
  assign ex_epc     = ex_bd ? (ex_pc - 32'd4) : ex_pc;

  // ---------------------------------------------------------------------------
  // Status / Cause / EPC / BadVAddr
  // ---------------------------------------------------------------------------
  // NOTE: state is updated only with non-blocking assignments; within one block
  // the last assignment wins, which is used below to express priority
  // (MTC0 first, then ERET, then exception overriding both).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      status_im     <= 8'd0;
      status_exl_q  <= 1'b0;
      status_ie     <= 1'b0;
      cause_bd      <= 1'b0;
      cause_ip_sw   <= 2'd0;
      cause_exccode <= 5'd0;
      epc           <= 32'd0;
      badvaddr      <= 32'd0;
    end else begin
      if (we_status) begin
        status_im    <= wb_wdata[15:8];
        status_exl_q <= wb_wdata[1];
        status_ie    <= wb_wdata[0];
      end
      if (we_cause)
        cause_ip_sw <= wb_wdata[9:8];
      if (we_epc && !epc_update)
        epc <= wb_wdata;

      if (eret)
        status_exl_q <= 1'b0;

      if (ex_valid) begin
        status_exl_q  <= 1'b1;
        cause_exccode <= ex_exccode;
      end
      if (epc_update) begin
        epc      <= ex_epc;
        cause_bd <= ex_bd;
      end
      if (bva_update)
        badvaddr <= ex_badvaddr;
    end
  end

  // ---------------------------------------------------------------------------
  // Count / Compare timer. Count advances every other cycle (when tick is 1).
  // ---------------------------------------------------------------------------
  logic [31:0] count_plus1;
  logic        ti_set;

  assign count_plus1 = count + 32'd1;
  assign ti_set      = we_count ? (wb_wdata == compare)
                                : (tick && (count_plus1 == compare));

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      count    <= 32'd0;
      tick     <= 1'b0;
      compare  <= 32'd0;
      cause_ti <= 1'b0;
    end else begin
      tick <= ~tick;
      if (we_count) begin
        count <= wb_wdata;
        tick  <= 1'b0;
      end else if (tick) begin
        count <= count_plus1;
      end

      if (we_compare)
        compare <= wb_wdata;

      // A Compare write acknowledges the timer interrupt and beats a
      // simultaneous match.
      if (we_compare)
        cause_ti <= 1'b0;
      else if (ti_set)
        cause_ti <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Optional TLB registers
  // ---------------------------------------------------------------------------
`ifdef CP0_TLB_REGS_EN
  localparam logic [31:0] INDEX_SW_MASK   = 32'h0000_000F;
  localparam logic [31:0] INDEX_TLBP_MASK = 32'h8000_000F;
  localparam logic [31:0] ENTRYLO_MASK    = 32'h03FF_FFFF;
  localparam logic [31:0] ENTRYHI_MASK    = 32'hFFFF_E0FF;

  logic [31:0] index_q, entrylo0, entrylo1, entryhi;
  logic        we_index, we_entrylo0, we_entrylo1, we_entryhi;

  assign we_index    = wr_sel0 && (wr_rd == RD_INDEX);
  assign we_entrylo0 = wr_sel0 && (wr_rd == RD_ENTRYLO0);
  assign we_entrylo1 = wr_sel0 && (wr_rd == RD_ENTRYLO1);
  assign we_entryhi  = wr_sel0 && (wr_rd == RD_ENTRYHI);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      index_q  <= 32'd0;
      entrylo0 <= 32'd0;
      entrylo1 <= 32'd0;
      entryhi  <= 32'd0;
    end else begin
      if (we_index)    index_q  <= wb_wdata & INDEX_SW_MASK;
      if (we_entrylo0) entrylo0 <= wb_wdata & ENTRYLO_MASK;
      if (we_entrylo1) entrylo1 <= wb_wdata & ENTRYLO_MASK;
      if (we_entryhi)  entryhi  <= wb_wdata & ENTRYHI_MASK;

      if (tlbp_valid)
        index_q <= tlbp_result & INDEX_TLBP_MASK;
      if (tlbr_valid) begin
        entryhi  <= tlbr_hi  & ENTRYHI_MASK;
        entrylo0 <= tlbr_lo0 & ENTRYLO_MASK;
        entrylo1 <= tlbr_lo1 & ENTRYLO_MASK;
      end

      if (ex_valid && is_tlb_exc)
        entryhi[31:13] <= ex_badvaddr[31:13];
    end
  end

  assign index_out    = index_q;
  assign entryhi_out  = entryhi;
  assign entrylo0_out = entrylo0;
  assign entrylo1_out = entrylo1;
`endif

  // ---------------------------------------------------------------------------
  // Read-side views
  // ---------------------------------------------------------------------------
  logic [7:0]  cause_ip;
  logic [31:0] status_rd, cause_rd;

  // IP[15] shares the top hardware line with the timer interrupt.
  assign cause_ip  = {ext_int[5] | cause_ti, ext_int[4:0], cause_ip_sw};
  assign status_rd = {9'd0, 1'b1, 6'd0, status_im, 6'd0, status_exl_q, status_ie};
  assign cause_rd  = {cause_bd, cause_ti, 14'd0, cause_ip, 1'b0, cause_exccode, 2'b00};

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    wb_rdata = 32'd0;
    if (wb_addr[2:0] == 3'd0) begin
      case (wb_addr[7:3])
        RD_BADVADDR: wb_rdata = badvaddr;
        RD_COUNT:    wb_rdata = count;
        RD_COMPARE:  wb_rdata = compare;
        RD_STATUS:   wb_rdata = status_rd;
        RD_CAUSE:    wb_rdata = cause_rd;
        RD_EPC:      wb_rdata = epc;
`ifdef CP0_TLB_REGS_EN
        RD_INDEX:    wb_rdata = index_q;
        RD_ENTRYLO0: wb_rdata = entrylo0;
        RD_ENTRYLO1: wb_rdata = entrylo1;
        RD_ENTRYHI:  wb_rdata = entryhi;
`endif
        default:     wb_rdata = 32'd0;
      endcase
    end
  end

  assign epc_out    = epc;
  assign exc_target = EXC_BASE;
  assign status_exl = status_exl_q;
  assign int_req    = status_ie && !status_exl_q && (|(cause_ip & status_im));

  // Simulation-only guard: WB should never commit ERET and an exception together.
  generate
    if (ERET_CHK != 0) begin : g_eret_chk
      always_ff @(posedge clk) begin
        if (resetn)
          assert (!(eret && ex_valid));
      end
    end
  endgenerate

endmodule

// File: tb/tb_cp0_regfile.sv
// -----------------------------------------------------------------------------
// tb_cp0_regfile -- directed self-checking bench for cp0_regfile.
// Inputs change just after the falling edge; outputs are read before the next
// rising edge. Clock period 100 ns so several reads fit between edges.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_cp0_regfile;

  localparam logic [7:0] A_BADVADDR = {5'd8,  3'd0};
  localparam logic [7:0] A_COUNT    = {5'd9,  3'd0};
  localparam logic [7:0] A_COMPARE  = {5'd11, 3'd0};
  localparam logic [7:0] A_STATUS   = {5'd12, 3'd0};
  localparam logic [7:0] A_CAUSE    = {5'd13, 3'd0};
  localparam logic [7:0] A_EPC      = {5'd14, 3'd0};
  localparam logic [7:0] A_EPC_SEL1 = {5'd14, 3'd1};
  localparam logic [7:0] A_INDEX    = {5'd0,  3'd0};

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_we;
  logic [7:0]  wb_addr;
  logic [31:0] wb_wdata;
  logic [31:0] wb_rdata;
  logic        ex_valid;
  logic [4:0]  ex_exccode;
  logic        ex_bd;
  logic [31:0] ex_pc;
  logic [31:0] ex_badvaddr;
  logic        eret;
  logic [5:0]  ext_int;
  logic [31:0] epc_out;
  logic [31:0] exc_target;
  logic        status_exl;
  logic        int_req;

  int vectors    = 0;
  int miscompares = 0;

  cp0_regfile #(.EXC_BASE(32'hBFC0_0380), .ERET_CHK(0)) dut (
    .clk(clk), .resetn(resetn),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
    .ex_valid(ex_valid), .ex_exccode(ex_exccode), .ex_bd(ex_bd), .ex_pc(ex_pc),
    .ex_badvaddr(ex_badvaddr), .eret(eret), .ext_int(ext_int),
    .epc_out(epc_out), .exc_target(exc_target), .status_exl(status_exl),
    .int_req(int_req)
  );

  always #50 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    wb_addr = addr;
    #1;
    data = wb_rdata;
  endtask

  task automatic mtc0(input logic [7:0] addr, input logic [31:0] data);
    wb_we = 1'b1; wb_addr = addr; wb_wdata = data;
    @(negedge clk);
    wb_we = 1'b0;
  endtask

  task automatic exc(input logic [4:0] code, input logic bd, input logic [31:0] pc,
                     input logic [31:0] bva);
    ex_valid = 1'b1; ex_exccode = code; ex_bd = bd; ex_pc = pc; ex_badvaddr = bva;
    @(negedge clk);
    ex_valid = 1'b0;
  endtask

  task automatic do_eret();
    eret = 1'b1;
    @(negedge clk);
    eret = 1'b0;
  endtask

  initial begin : stim
    logic [31:0] v;
    bit          found;

    resetn = 1'b0; wb_we = 1'b0; wb_addr = 8'd0; wb_wdata = 32'd0;
    ex_valid = 1'b0; ex_exccode = 5'd0; ex_bd = 1'b0; ex_pc = 32'd0;
    ex_badvaddr = 32'd0; eret = 1'b0; ext_int = 6'd0;
    repeat (3) @(negedge clk);
    resetn = 1'b1;

    // 1. Reset values
    rd(A_STATUS, v);   check("rst_status", v, 32'h0040_0000);
    rd(A_CAUSE, v);    check("rst_cause", v, 32'd0);
    rd(A_EPC, v);      check("rst_epc", v, 32'd0);
    rd(A_COUNT, v);    check("rst_count", v, 32'd0);
    rd(A_COMPARE, v);  check("rst_compare", v, 32'd0);
    rd(A_BADVADDR, v); check("rst_badvaddr", v, 32'd0);
    check("rst_int_req", {31'd0, int_req}, 32'd0);
    check("exc_target", exc_target, 32'hBFC0_0380);

    // 2. Count/Compare timer
    mtc0(A_COUNT, 32'd0);
    mtc0(A_COMPARE, 32'd5);
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      rd(A_COUNT, v);
      if (v == 32'd4) found = 1'b1;
      else @(negedge clk);
    end
    check("count_reach4", {31'd0, found}, 32'd1);
    rd(A_CAUSE, v);  check("ti_at_count4", v, 32'd0);
    @(negedge clk);
    rd(A_COUNT, v);  check("count_hold4", v, 32'd4);
    rd(A_CAUSE, v);  check("ti_one_cycle", v, 32'd0);
    @(negedge clk);
    rd(A_COUNT, v);  check("count_5", v, 32'd5);
    rd(A_CAUSE, v);  check("ti_set", v, 32'h4000_8000);
    mtc0(A_COMPARE, 32'd5);
    rd(A_CAUSE, v);  check("ti_cleared", v, 32'd0);

    // 3. Exceptions
    exc(5'd4, 1'b1, 32'h8000_0010, 32'h0000_0001);
    rd(A_EPC, v);      check("exc_epc", v, 32'h8000_000C);
    check("epc_out", epc_out, 32'h8000_000C);
    rd(A_CAUSE, v);    check("exc_cause", v, 32'h8000_0010);
    rd(A_STATUS, v);   check("exc_status", v, 32'h0040_0002);
    check("exc_exl_port", {31'd0, status_exl}, 32'd1);
    rd(A_BADVADDR, v); check("exc_badvaddr", v, 32'h0000_0001);
    exc(5'd8, 1'b0, 32'h0000_0200, 32'h0000_DEAD);
    rd(A_EPC, v);      check("nested_epc", v, 32'h8000_000C);
    rd(A_CAUSE, v);    check("nested_cause", v, 32'h8000_0020);
    rd(A_BADVADDR, v); check("nested_badvaddr", v, 32'h0000_0001);
    do_eret();
    rd(A_STATUS, v);   check("eret_status", v, 32'h0040_0000);

    // 4. Interrupts
    mtc0(A_STATUS, 32'h0000_0401);
    rd(A_STATUS, v);   check("status_wr", v, 32'h0040_0401);
    check("int_none", {31'd0, int_req}, 32'd0);
    ext_int = 6'b000001;
    @(negedge clk);
    check("int_hw0", {31'd0, int_req}, 32'd1);
    rd(A_CAUSE, v);    check("cause_ip10", v, 32'h8000_0420);
    exc(5'd0, 1'b0, 32'h0000_0300, 32'd0);
    check("int_masked_exl", {31'd0, int_req}, 32'd0);
    rd(A_EPC, v);      check("int_epc", v, 32'h0000_0300);
    rd(A_CAUSE, v);    check("int_cause", v, 32'h0000_0400);
    do_eret();
    check("int_after_eret", {31'd0, int_req}, 32'd1);
    ext_int = 6'd0;
    mtc0(A_CAUSE, 32'hFFFF_FFFF);
    rd(A_CAUSE, v);    check("cause_sw_mask", v, 32'h0000_0300);
    check("int_sw_not_enabled", {31'd0, int_req}, 32'd0);
    mtc0(A_CAUSE, 32'd0);

    // 5. Same-cycle priority: exception > eret > MTC0
    ex_valid = 1'b1; ex_exccode = 5'd5; ex_bd = 1'b0; ex_pc = 32'h0000_0400;
    ex_badvaddr = 32'h0000_1234; eret = 1'b1;
    mtc0(A_STATUS, 32'd0);
    ex_valid = 1'b0; eret = 1'b0;
    rd(A_STATUS, v);   check("prio_status", v, 32'h0040_0002);
    rd(A_EPC, v);      check("prio_epc", v, 32'h0000_0400);
    rd(A_BADVADDR, v); check("prio_badvaddr", v, 32'h0000_1234);
    rd(A_CAUSE, v);    check("prio_cause", v, 32'h0000_0014);
    do_eret();

    // EPC write: old value during the write cycle, new value after the edge
    wb_we = 1'b1; wb_addr = A_EPC; wb_wdata = 32'hBFC0_0000;
    #1;
    check("epc_old_in_wr_cycle", wb_rdata, 32'h0000_0400);
    @(negedge clk);
    wb_we = 1'b0;
    rd(A_EPC, v);      check("epc_wr", v, 32'hBFC0_0000);
    mtc0(A_EPC_SEL1, 32'h1111_1111);
    rd(A_EPC, v);      check("epc_sel1_ignored", v, 32'hBFC0_0000);
    rd(A_EPC_SEL1, v); check("sel1_reads0", v, 32'd0);
    mtc0(A_INDEX, 32'hFFFF_FFFF);
    rd(A_INDEX, v);    check("unimpl_reads0", v, 32'd0);

    // 6. Count wrap (Compare=5, so no TI)
    mtc0(A_COUNT, 32'hFFFF_FFFF);
    rd(A_COUNT, v);    check("wrap_c0", v, 32'hFFFF_FFFF);
    @(negedge clk);
    rd(A_COUNT, v);    check("wrap_c1", v, 32'hFFFF_FFFF);
    @(negedge clk);
    rd(A_COUNT, v);    check("wrap_c2", v, 32'd0);
    rd(A_CAUSE, v);    check("wrap_no_ti", v, 32'h0000_0014);

    // Count write equal to Compare raises TI
    mtc0(A_COUNT, 32'd5);
    rd(A_COUNT, v);    check("cnt_eq_cmp_count", v, 32'd5);
    rd(A_CAUSE, v);    check("cnt_eq_cmp_ti", v, 32'h4000_8014);

    // Asynchronous reset mid-operation
    #10;
    resetn = 1'b0;
    #1;
    rd(A_STATUS, v);   check("arst_status", v, 32'h0040_0000);
    rd(A_EPC, v);      check("arst_epc", v, 32'd0);
    rd(A_COMPARE, v);  check("arst_compare", v, 32'd0);
    rd(A_COUNT, v);    check("arst_count", v, 32'd0);
    rd(A_CAUSE, v);    check("arst_cause", v, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
